// File: rtl/pll_pkg.sv
// -----------------------------------------------------------------------------
// pll_pkg
//   Shared definitions for the PLL bring-up sequencer and its helpers.
//   - pll_state_e   : sequencer state encoding
//   - LOSS_W        : width of the lock-loss event counter
//   - max3()        : constant helper used to size the shared cycle counter
// -----------------------------------------------------------------------------
package pll_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,   // PLL RESETB held low
        WAIT_LOCK = 2'd1,   // waiting for synchronised lock, with timeout
        STABLE    = 2'd2,   // lock present, counting consecutive locked cycles
        RUN       = 2'd3    // downstream domain released
    } pll_state_e;

    localparam int LOSS_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync2.sv
// -----------------------------------------------------------------------------
// sync2
//   Two-flop synchroniser for a single asynchronous level signal.
//   Also suitable for re-timing sys_reset into the PLL output clock domain.
// Ports
//   clock  in  destination clock
//   reset  in  synchronous, active-high; loads INIT into both flops
//   d_i    in  asynchronous input level
//   q_o    out synchronised level, two clock cycles of latency
// -----------------------------------------------------------------------------
module sync2 #(
    parameter logic INIT = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    // Only sync_q[0] may go metastable; sync_q[1] is the safe output.
    logic [1:0] sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= {2{INIT}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
//   Brings up an iCE40 SB_PLL40_CORE and hands a clean reset to the
//   PLL-clocked logic. Runs entirely on the PLL reference clock.
//   The PLL is pulsed into reset, lock is awaited (with timeout and retry),
//   lock must then be stable for STABLE_CYCLES before sys_reset releases.
//   A lock drop while running reasserts sys_reset without resetting the PLL.
// Ports
//   clock       in   reference clock, all logic on this clock
//   reset       in   synchronous, active-high
//   pll_locked  in   PLL LOCK, asynchronous to clock
//   pll_resetb  out  PLL RESETB, 0 holds the PLL in reset
//   sys_reset   out  active-high reset for the PLL-clocked domain
//   ready       out  high while running (~sys_reset)
//   fail        out  sticky, lock timed out more than MAX_RETRIES times
//   lock_lost   out  sticky, lock dropped at least once while running
//   loss_count  out  running->lock-loss events, saturating at 255
// -----------------------------------------------------------------------------
module pll_lock_sequencer
    import pll_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 4,
    parameter int LOCK_TIMEOUT   = 4800,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pll_locked,
    output logic              pll_resetb,
    output logic              sys_reset,
    output logic              ready,
    output logic              fail,
    output logic              lock_lost,
    output logic [LOSS_W-1:0] loss_count
);

    // One counter serves all timed states; sized for the longest interval.
    localparam int CNT_W = $clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;
    // Retry count saturates one past MAX_RETRIES, the point where fail is raised.
    localparam int RET_W = $clog2(MAX_RETRIES + 2);

    localparam logic [CNT_W-1:0]  RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RET_W-1:0]  RETRY_FAIL  = RET_W'(MAX_RETRIES);
    localparam logic [RET_W-1:0]  RETRY_SAT   = RET_W'(MAX_RETRIES + 1);
    localparam logic [LOSS_W-1:0] LOSS_SAT    = {LOSS_W{1'b1}};

    pll_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RET_W-1:0]  retries_q, retries_d;
    logic              fail_q, fail_d;
    logic              lock_lost_q, lock_lost_d;
    logic [LOSS_W-1:0] loss_count_q, loss_count_d;
    logic              pll_resetb_q;
    logic              sys_reset_q;
    logic              lk;

    // ------------------------------------------------------------------
    // Lock synchroniser: lk is the only form of pll_locked used below.
    // ------------------------------------------------------------------
    sync2 #(
        .INIT (1'b0)
    ) u_lock_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (pll_locked),
        .q_o   (lk)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        retries_d    = retries_q;
        fail_d       = fail_q;
        lock_lost_d  = lock_lost_q;
        loss_count_d = loss_count_q;

        unique case (state_q)
            PLL_RST: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                end
            end

            WAIT_LOCK: begin
                cnt_d = cnt_q + 1'b1;
                if (lk) begin
                    state_d = STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = PLL_RST;
                    if (retries_q != RETRY_SAT) begin
                        retries_d = retries_q + 1'b1;
                    end
                    // This timeout takes the count to MAX_RETRIES+1 (or beyond).
                    if (retries_q >= RETRY_FAIL) begin
                        fail_d = 1'b1;
                    end
                end
            end

            STABLE: begin
                cnt_d = cnt_q + 1'b1;
                // A drop here is not a PLL failure, so no retry is charged.
                if (!lk) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d   = RUN;
                    retries_d = '0;
                end
            end

            RUN: begin
                if (!lk) begin
                    state_d     = WAIT_LOCK;
                    lock_lost_d = 1'b1;
                    if (loss_count_q != LOSS_SAT) begin
                        loss_count_d = loss_count_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = PLL_RST;
            end
        endcase

        // Every state's timing starts from zero on entry.
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // State and output registers. Outputs are decoded from state_d so they
    // change on the same edge as the state, with no path from pll_locked.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= PLL_RST;
            cnt_q        <= '0;
            retries_q    <= '0;
            fail_q       <= 1'b0;
            lock_lost_q  <= 1'b0;
            loss_count_q <= '0;
            pll_resetb_q <= 1'b0;
            sys_reset_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retries_q    <= retries_d;
            fail_q       <= fail_d;
            lock_lost_q  <= lock_lost_d;
            loss_count_q <= loss_count_d;
            pll_resetb_q <= (state_d != PLL_RST);
            sys_reset_q  <= (state_d != RUN);
        end
    end

    assign pll_resetb = pll_resetb_q;
    assign sys_reset  = sys_reset_q;
    assign ready      = ~sys_reset_q;
    assign fail       = fail_q;
    assign lock_lost  = lock_lost_q;
    assign loss_count = loss_count_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_sequencer
//   Directed stimulus schedules expected output vectors for future cycles into
//   a scoreboard queue; a negedge monitor pops and compares them.
//   Vector layout: {pll_resetb, sys_reset, ready, fail, lock_lost, loss_count}.
//   Cycle offsets below are counted in rising edges from the phase origin.
// -----------------------------------------------------------------------------
module tb_pll_lock_sequencer;
    import pll_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              pll_locked;
    logic              pll_resetb;
    logic              sys_reset;
    logic              ready;
    logic              fail;
    logic              lock_lost;
    logic [LOSS_W-1:0] loss_count;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        string       tag;
        logic [12:0] v;
    } exp_t;

    exp_t sb_q[$];

    pll_lock_sequencer #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (16),
        .STABLE_CYCLES  (8),
        .MAX_RETRIES    (2)
    ) dut (
        .clock      (clk),
        .reset      (rst),
        .pll_locked (pll_locked),
        .pll_resetb (pll_resetb),
        .sys_reset  (sys_reset),
        .ready      (ready),
        .fail       (fail),
        .lock_lost  (lock_lost),
        .loss_count (loss_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every scheduled vector on the falling edge of its cycle.
    always @(negedge clk) begin
        logic [12:0] act;
        exp_t        e;
        act = {pll_resetb, sys_reset, ready, fail, lock_lost, loss_count};
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            checks++;
            if (e.cyc != cyc || act !== e.v) begin
                errors++;
                $display("FAIL %s cyc=%0d (due %0d) got rb=%b sr=%b rdy=%b f=%b ll=%b lc=%0d want rb=%b sr=%b rdy=%b f=%b ll=%b lc=%0d",
                         e.tag, cyc, e.cyc, act[12], act[11], act[10], act[9], act[8], act[7:0],
                         e.v[12], e.v[11], e.v[10], e.v[9], e.v[8], e.v[7:0]);
            end else begin
                $display("check %s cyc=%0d rb=%b sr=%b rdy=%b f=%b ll=%b lc=%0d ok",
                         e.tag, cyc, act[12], act[11], act[10], act[9], act[8], act[7:0]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int dc, input string tag, input logic rb, input logic sr,
                             input logic f, input logic ll, input int lc);
        exp_t e;
        e.cyc = cyc + dc;
        e.tag = tag;
        e.v   = {rb, sr, ~sr, f, ll, 8'(lc)};
        sb_q.push_back(e);
    endtask

    task automatic expect_span(input int a, input int b, input string tag, input logic rb,
                               input logic sr, input logic f, input logic ll, input int lc);
        for (int k = a; k <= b; k++) expect_at(k, tag, rb, sr, f, ll, lc);
    endtask

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b1;
        tick(2);

        // ---- 1: locked from the start. PLL_RST for 4 cycles after release;
        // lk is already 1 when WAIT_LOCK is entered at edge 4, so STABLE starts
        // at edge 5 and RUN follows 8 cycles later at edge 13.
        expect_at(0, "reset_vals", 0, 1, 0, 0, 0);
        rst = 1'b0;
        expect_span(1, 3, "t1_pll_rst", 0, 1, 0, 0, 0);
        expect_span(4, 12, "t1_wait_stable", 1, 1, 0, 0, 0);
        expect_at(13, "t1_run", 1, 0, 0, 0, 0);
        tick(13);

        // ---- 4: lock falls in RUN: 2 sync edges + 1 -> sys_reset at edge 3.
        pll_locked = 1'b0;
        expect_span(1, 2, "t4_still_run", 1, 0, 0, 0, 0);
        expect_at(3, "t4_loss", 1, 1, 0, 1, 1);
        tick(3);
        // Relock: lk=1 at edge 2, STABLE at edge 3, RUN at edge 11.
        pll_locked = 1'b1;
        expect_span(1, 10, "t4_relock", 1, 1, 0, 1, 1);
        expect_at(11, "t4_run", 1, 0, 0, 1, 1);
        tick(11);

        // ---- 5: 260 one-cycle lock drops in RUN; count saturates at 255.
        // Drop after edge 0, restore after edge 1: WAIT_LOCK at 3, STABLE at 4, RUN at 12.
        for (int i = 0; i < 260; i++) begin
            int n;
            n = (2 + i > 255) ? 255 : 2 + i;
            expect_at(3, "t5_loss", 1, 1, 0, 1, n);
            expect_at(12, "t5_run", 1, 0, 0, 1, n);
            pll_locked = 1'b0;
            tick(1);
            pll_locked = 1'b1;
            tick(11);
        end

        // ---- 6a: reset while in RUN clears everything on the next edge.
        rst = 1'b1;
        expect_at(1, "t6_rst_in_run", 0, 1, 0, 0, 0);
        tick(1);
        rst = 1'b0;
        // From the reset edge: WAIT_LOCK at 4, STABLE at 5; edge 7 is STABLE cnt=2.
        expect_span(1, 3, "t6_pll_rst", 0, 1, 0, 0, 0);
        expect_span(4, 7, "t6_to_stable", 1, 1, 0, 0, 0);
        tick(7);

        // ---- 6b: reset while in STABLE.
        rst = 1'b1;
        expect_at(1, "t6_rst_in_stable", 0, 1, 0, 0, 0);
        tick(1);
        rst = 1'b0;

        // ---- 3: from the reset edge: STABLE at 5, cnt=5 at edge 10. A one-cycle
        // drop makes lk=0 in that cycle -> WAIT_LOCK at 11, STABLE at 12, RUN at 20.
        expect_span(1, 3, "t3_pll_rst", 0, 1, 0, 0, 0);
        expect_span(4, 19, "t3_hold", 1, 1, 0, 0, 0);
        expect_at(20, "t3_run", 1, 0, 0, 0, 0);
        tick(8);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(11);

        // ---- 2: no lock. PLL pulse every 20 cycles, fail at the 3rd timeout (edge 60).
        rst        = 1'b1;
        pll_locked = 1'b0;
        expect_at(1, "t2_reset", 0, 1, 0, 0, 0);
        tick(1);
        rst = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            expect_at(k, "t2_retry", ((k % 20) >= 4), 1, (k >= 60), 0, 0);
        end
        tick(80);
        // Edge 80 is the start of a PLL pulse; lock now arrives: RUN at edge 13.
        pll_locked = 1'b1;
        expect_span(1, 3, "t2_pll_rst", 0, 1, 1, 0, 0);
        expect_span(4, 12, "t2_relock", 1, 1, 1, 0, 0);
        expect_at(13, "t2_run_fail_sticky", 1, 0, 1, 0, 0);
        tick(13);

        tick(2);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
